// File: rtl/pack_pkg.sv
// Shared constants and lane type for the 16-to-64 packer.
// Used by pack_lane_ctrl and pack16_to_64.
package pack_pkg;

   localparam int PACK_LANE_W = 16;
   localparam int PACK_LANES  = 4;
   localparam int PACK_CNT_W  = 2;

   typedef logic [PACK_LANE_W-1:0] pack_lane_t;

endpackage

// File: rtl/pack_lane_ctrl.sv
// Lane counter, accept/complete/flush decode and write strobe.
// Optional PACK_FLUSH_EN adds the flush input.
module pack_lane_ctrl
   import pack_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  stall,
`ifdef PACK_FLUSH_EN
   input  logic                  flush,
`endif
   output logic                  in_ready,
   output logic                  accept,
   output logic                  emit,
   output logic [PACK_CNT_W-1:0] count,
   output logic                  write
);

   logic [PACK_CNT_W-1:0] cnt_q, cnt_d;
   logic                  write_q, write_d;
   logic                  full;

   assign in_ready = !stall;
   assign accept   = in_valid & in_ready;
   assign full     = (cnt_q == PACK_CNT_W'(PACK_LANES - 1));

   always_comb begin
      emit = accept & full;
`ifdef PACK_FLUSH_EN
      // a flush only emits when there is at least one word to send
      if (flush && ((cnt_q != '0) || accept)) begin
         emit = 1'b1;
      end
`endif
   end

   always_comb begin
      cnt_d   = cnt_q;
      write_d = emit;
      if (emit) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d = cnt_q + PACK_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q   <= '0;
         write_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         write_q <= write_d;
      end
   end

   assign count = cnt_q;
   assign write = write_q;

endmodule

// File: rtl/pack16_to_64.sv
// Packs 16-bit words little-endian into 64-bit register writes.
// Optional PACK_FLUSH_EN adds a flush port that emits partial groups.
module pack16_to_64
   import pack_pkg::*;
#(
   parameter int LANE_W = 16,
   parameter int LANES  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LANE_W-1:0]       in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    stall,
`ifdef PACK_FLUSH_EN
   input  logic                    flush,
`endif
   output logic [LANES*LANE_W-1:0] writedata,
   output logic                    write,
   output logic [PACK_CNT_W-1:0]   count
);

   if (LANE_W != PACK_LANE_W || LANES != PACK_LANES) begin : g_bad_cfg
      $error("pack16_to_64: only LANE_W=16, LANES=4 supported");
   end

   // lane 3 is never stored: it comes straight from in_data on completion
   pack_lane_t                      lane_q [PACK_LANES-1];
   pack_lane_t                      lane_d [PACK_LANES-1];
   logic [PACK_LANES*PACK_LANE_W-1:0] wdata_q, wdata_d;
   logic                            accept;
   logic                            emit;
   logic [PACK_CNT_W-1:0]           cnt;

   pack_lane_ctrl u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .stall    (stall),
`ifdef PACK_FLUSH_EN
      .flush    (flush),
`endif
      .in_ready (in_ready),
      .accept   (accept),
      .emit     (emit),
      .count    (cnt),
      .write    (write)
   );

   always_comb begin
      for (int i = 0; i < PACK_LANES - 1; i++) begin
         lane_d[i] = lane_q[i];
         if (accept && (PACK_CNT_W'(i) == cnt)) begin
            lane_d[i] = in_data;
         end
      end
   end

   // lanes below cnt are filled, lane cnt takes in_data, the rest are zero
   always_comb begin
      wdata_d = wdata_q;
      if (emit) begin
         wdata_d = '0;
         for (int i = 0; i < PACK_LANES - 1; i++) begin
            if (PACK_CNT_W'(i) < cnt) begin
               wdata_d[i*PACK_LANE_W +: PACK_LANE_W] = lane_q[i];
            end else if (accept && (PACK_CNT_W'(i) == cnt)) begin
               wdata_d[i*PACK_LANE_W +: PACK_LANE_W] = in_data;
            end
         end
         if (accept && (cnt == PACK_CNT_W'(PACK_LANES - 1))) begin
            wdata_d[(PACK_LANES-1)*PACK_LANE_W +: PACK_LANE_W] = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wdata_q <= '0;
         for (int i = 0; i < PACK_LANES - 1; i++) begin
            lane_q[i] <= '0;
         end
      end else begin
         wdata_q <= wdata_d;
         for (int i = 0; i < PACK_LANES - 1; i++) begin
            lane_q[i] <= lane_d[i];
         end
      end
   end

   assign writedata = wdata_q;
   assign count     = cnt;

endmodule

// File: tb/tb_pack16_to_64.sv
// Directed self-checking bench for pack16_to_64.
// Flush steps are included when PACK_FLUSH_EN is defined.
module tb_pack16_to_64;

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        stall;
   logic        flush;
   logic [63:0] writedata;
   logic        write;
   logic [1:0]  count;

   int errors = 0;
   int checks = 0;
   int npulse;

   pack16_to_64 dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .stall     (stall),
`ifdef PACK_FLUSH_EN
      .flush     (flush),
`endif
      .writedata (writedata),
      .write     (write),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one edge, leave time 1 past it for sampling/driving
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] d);
      in_data  = d;
      in_valid = 1'b1;
      step();
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      stall    = 1'b0;
      flush    = 1'b0;
      step();
      step();
      chk("rst_wdata", writedata, 64'h0);
      chk("rst_write", {63'h0, write}, 64'h0);
      chk("rst_count", {62'h0, count}, 64'h0);
      chk("rst_ready", {63'h0, in_ready}, 64'h1);
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      chk("idle_count", {62'h0, count}, 64'h0);

      // basic pack
      push(16'h1111);
      push(16'h2222);
      push(16'h3333);
      chk("basic_cnt3", {62'h0, count}, 64'h3);
      chk("basic_nowr", {63'h0, write}, 64'h0);
      chk("basic_hold0", writedata, 64'h0);
      push(16'h4444);
      chk("basic_write", {63'h0, write}, 64'h1);
      chk("basic_wdata", writedata, 64'h4444_3333_2222_1111);
      chk("basic_cnt0", {62'h0, count}, 64'h0);
      in_valid = 1'b0;
      step();
      chk("basic_1cyc", {63'h0, write}, 64'h0);
      chk("basic_held", writedata, 64'h4444_3333_2222_1111);

      // back-to-back groups
      npulse = 0;
      for (int k = 0; k < 8; k++) begin
         push(16'(k + 1));
         if (write) npulse++;
         chk($sformatf("b2b_wr%0d", k), {63'h0, write},
             (k == 3 || k == 7) ? 64'h1 : 64'h0);
         if (k == 3) chk("b2b_g1", writedata, 64'h0004_0003_0002_0001);
         if (k == 7) chk("b2b_g2", writedata, 64'h0008_0007_0006_0005);
      end
      in_valid = 1'b0;
      step();
      chk("b2b_pulses", 64'(npulse), 64'd2);
      chk("b2b_after", {63'h0, write}, 64'h0);

      // stall after two accepts
      push(16'hA001);
      push(16'hA002);
      stall    = 1'b1;
      in_valid = 1'b1;
      in_data  = 16'hFFFF;
      #1;
      chk("stall_ready", {63'h0, in_ready}, 64'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("stall_cnt%0d", k), {62'h0, count}, 64'h2);
         chk($sformatf("stall_wr%0d", k), {63'h0, write}, 64'h0);
      end
      stall = 1'b0;
      #1;
      chk("unstall_ready", {63'h0, in_ready}, 64'h1);
      push(16'hA003);
      push(16'hA004);
      chk("stall_write", {63'h0, write}, 64'h1);
      chk("stall_wdata", writedata, 64'hA004_A003_A002_A001);
      in_valid = 1'b0;
      step();

      // reset mid-group
      push(16'hC001);
      push(16'hC002);
      push(16'hC003);
      in_valid = 1'b0;
      rst      = 1'b0;
      step();
      chk("mrst_count", {62'h0, count}, 64'h0);
      chk("mrst_wdata", writedata, 64'h0);
      rst = 1'b1;
      push(16'hD001);
      push(16'hD002);
      push(16'hD003);
      chk("mrst_nowr", {63'h0, write}, 64'h0);
      push(16'hD004);
      chk("mrst_write", {63'h0, write}, 64'h1);
      chk("mrst_wdata2", writedata, 64'hD004_D003_D002_D001);
      in_valid = 1'b0;
      step();

`ifdef PACK_FLUSH_EN
      push(16'hAAAA);
      push(16'hBBBB);
      in_valid = 1'b0;
      flush    = 1'b1;
      step();
      chk("flush_write", {63'h0, write}, 64'h1);
      chk("flush_wdata", writedata, 64'h0000_0000_BBBB_AAAA);
      chk("flush_count", {62'h0, count}, 64'h0);
      step();
      chk("flush_idle", {63'h0, write}, 64'h0);
      chk("flush_idle_wd", writedata, 64'h0000_0000_BBBB_AAAA);
      flush = 1'b0;
      step();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
